pio_adder_engine: RTL and testbench

Fabric-side consumer of the HPS PIO operand exports. It takes the two 64-bit operands written by software and returns their sum to the HPS sum PIO input. Software writes the A and B PIOs separately, so the block waits for both operands to be stable before computing. It then adds over several cycles, CHUNK_W bits per cycle, and updates the sum output in a single write so software never reads a half-finished value.

---
 rtl/pio_adder_pkg.sv | 23 ++
 rtl/pio_adder_engine_if.sv | 33 +++
 rtl/pio_adder_chunk.sv | 14 +
 rtl/pio_adder_engine.sv | 150 +++++++++++++++
 tb/tb_pio_adder_engine.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/pio_adder_pkg.sv
// rtl/pio_adder_pkg.sv - shared types, defaults and sizing helpers for the PIO adder engine
package pio_adder_pkg;

    localparam int DEFAULT_DATA_W        = 64;
    localparam int DEFAULT_CHUNK_W       = 16;
    localparam int DEFAULT_SETTLE_CYCLES = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        ADD    = 2'd2
    } state_e;

    function automatic int nchunk(input int data_w, input int chunk_w);
        return data_w / chunk_w;
    endfunction

    // Bits needed to count 0..n-1, never less than one so degenerate sizes still elaborate.
    function automatic int width_for(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pio_adder_engine_if.sv
// rtl/pio_adder_engine_if.sv - operand/result bundle between the HPS PIO exports and the adder engine
interface pio_adder_engine_if
    import pio_adder_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
);

    logic [DATA_W-1:0] adder_a;
    logic [DATA_W-1:0] adder_b;
    logic [DATA_W-1:0] adder_sum;
    logic              carry_out;
    logic              busy;
    logic              done;

    modport master (
        output adder_a,
        output adder_b,
        input  adder_sum,
        input  carry_out,
        input  busy,
        input  done
    );

    modport slave (
        input  adder_a,
        input  adder_b,
        output adder_sum,
        output carry_out,
        output busy,
        output done
    );

endinterface

// File: rtl/pio_adder_chunk.sv
// rtl/pio_adder_chunk.sv - combinational W-bit adder slice with carry in and carry out
module pio_adder_chunk #(
    parameter int W = 16
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         c_i,
    output logic [W-1:0] s_o,
    output logic         c_o
);

    assign {c_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, c_i};

endmodule

// File: rtl/pio_adder_engine.sv
// rtl/pio_adder_engine.sv - waits for stable PIO operands, adds them chunk by chunk, publishes the sum atomically
module pio_adder_engine
    import pio_adder_pkg::*;
#(
    parameter int DATA_W        = DEFAULT_DATA_W,
    parameter int CHUNK_W       = DEFAULT_CHUNK_W,
    parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES
) (
    input  logic                clk_clk,
    input  logic                reset_reset_n,
    pio_adder_engine_if.slave   bus
);

    localparam int NCHUNK = nchunk(DATA_W, CHUNK_W);
    localparam int IDX_W  = width_for(NCHUNK);
    localparam int CNT_W  = width_for(SETTLE_CYCLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SETTLE_CYCLES - 1);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] sh_a_q, sh_a_d, sh_b_q, sh_b_d;
    logic [DATA_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
    logic [DATA_W-1:0] part_q, part_d;
    logic [DATA_W-1:0] sum_q, sum_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              carry_q, carry_d;
    logic              cout_q, cout_d;
    logic              done_q, done_d;

    logic [CHUNK_W-1:0] a_chunk, b_chunk, chunk_sum;
    logic               chunk_co;
    logic [DATA_W-1:0]  part_next;

    // Select the operand slice for the current chunk and splice its sum into the partial result.
    always_comb begin
        a_chunk   = '0;
        b_chunk   = '0;
        part_next = part_q;
        for (int i = 0; i < NCHUNK; i++) begin
            if (idx_q == IDX_W'(i)) begin
                a_chunk = op_a_q[i*CHUNK_W +: CHUNK_W];
                b_chunk = op_b_q[i*CHUNK_W +: CHUNK_W];
                part_next[i*CHUNK_W +: CHUNK_W] = chunk_sum;
            end
        end
    end

    pio_adder_chunk #(
        .W (CHUNK_W)
    ) u_chunk (
        .a_i (a_chunk),
        .b_i (b_chunk),
        .c_i (carry_q),
        .s_o (chunk_sum),
        .c_o (chunk_co)
    );

    always_comb begin
        state_d = state_q;
        sh_a_d  = sh_a_q;
        sh_b_d  = sh_b_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        part_d  = part_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if ({bus.adder_a, bus.adder_b} != {op_a_q, op_b_q}) begin
                    sh_a_d  = bus.adder_a;
                    sh_b_d  = bus.adder_b;
                    cnt_d   = '0;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                // Any movement restarts the stability window; software writes A and B separately.
                if ({bus.adder_a, bus.adder_b} != {sh_a_q, sh_b_q}) begin
                    sh_a_d = bus.adder_a;
                    sh_b_d = bus.adder_b;
                    cnt_d  = '0;
                end else if (cnt_q == LAST_CNT) begin
                    op_a_d  = bus.adder_a;
                    op_b_d  = bus.adder_b;
                    idx_d   = '0;
                    carry_d = 1'b0;
                    state_d = ADD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ADD: begin
                part_d  = part_next;
                carry_d = chunk_co;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    sum_d   = part_next;
                    cout_d  = chunk_co;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state_q <= IDLE;
            sh_a_q  <= '0;
            sh_b_q  <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            part_q  <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_a_q  <= sh_a_d;
            sh_b_q  <= sh_b_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            part_q  <= part_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            done_q  <= done_d;
        end
    end

    assign bus.adder_sum = sum_q;
    assign bus.carry_out = cout_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;

endmodule

// File: tb/tb_pio_adder_engine.sv
// tb/tb_pio_adder_engine.sv - self-checking bench for pio_adder_engine
module tb_pio_adder_engine;

    localparam int DW  = 64;
    localparam int CW  = 16;
    localparam int SC  = 4;
    localparam int NC  = DW / CW;
    localparam int LAT = 1 + SC + NC;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] sum;
        logic          c;
    } vec_t;

    typedef struct {
        logic [DW-1:0] sum;
        logic          c;
    } exp_t;

    logic    clk = 1'b0;
    logic    rstn;
    int      cyc = 0;
    int      tests = 0;
    int      fails = 0;
    int      done_cnt = 0;
    int      done_cyc = 0;
    exp_t    sb[$];
    exp_t    mon_e;
    logic [DW-1:0] prev_sum;
    logic    prev_rstn = 1'b0;
    vec_t    vt[10];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pio_adder_engine_if #(.DATA_W(DW)) bus();

    pio_adder_engine #(
        .DATA_W        (DW),
        .CHUNK_W       (CW),
        .SETTLE_CYCLES (SC)
    ) dut (
        .clk_clk       (clk),
        .reset_reset_n (rstn),
        .bus           (bus)
    );

    task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int prev, input int limit, output int busy_n, output bit ok);
        busy_n = 0;
        ok     = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt > prev) ok = 1'b1;
            else if (bus.busy) busy_n++;
        end
    endtask

    // Scoreboard pop on every done pulse, plus a hold check between done edges.
    always @(negedge clk) begin
        if (rstn === 1'b1 && bus.done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("sum", bus.adder_sum, mon_e.sum);
                check("carry_out", bus.carry_out, mon_e.c);
            end
        end
        if (rstn === 1'b1 && prev_rstn === 1'b1 && bus.done !== 1'b1)
            check("sum_hold", bus.adder_sum, prev_sum);
        prev_sum  = bus.adder_sum;
        prev_rstn = rstn;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int  n, m, prev, bc, d1;
        bit  ok, busy_seen;

        vt[0] = '{64'd5, 64'd7, 64'd12, 1'b0};
        vt[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1};
        vt[2] = '{64'h0000_0000_0000_FFFF, 64'd1, 64'h0000_0000_0001_0000, 1'b0};
        vt[3] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd0, 1'b1};
        vt[4] = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 64'h2222_2222_2222_2211, 1'b0};
        vt[5] = '{64'hFFFF_0000_FFFF_0000, 64'h0001_0000_0001_0000, 64'h0000_0001_0000_0000, 1'b1};
        for (int i = 6; i < 10; i++) begin
            vt[i].a = {$urandom(), $urandom()};
            vt[i].b = {$urandom(), $urandom()};
            {vt[i].c, vt[i].sum} = {1'b0, vt[i].a} + {1'b0, vt[i].b};
        end

        rstn        = 1'b0;
        bus.adder_a = '0;
        bus.adder_b = '0;
        step(3);
        check("reset_sum", bus.adder_sum, 0);
        check("reset_done", bus.done, 0);
        rstn = 1'b1;

        busy_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (bus.busy) busy_seen = 1'b1;
        end
        check("idle_zero_busy", busy_seen, 0);
        check("idle_zero_done_cnt", done_cnt, 0);
        check("idle_zero_sum", bus.adder_sum, 0);
        check("idle_zero_carry", bus.carry_out, 0);

        for (int i = 0; i < 10; i++) begin
            bus.adder_a = vt[i].a;
            bus.adder_b = vt[i].b;
            sb.push_back('{vt[i].sum, vt[i].c});
            n    = cyc;
            prev = done_cnt;
            wait_done(prev, 60, bc, ok);
            check("vec_done_seen", ok, 1);
            if (ok) begin
                check("vec_latency", done_cyc - n, LAT);
                check("vec_busy_cycles", bc, SC + NC);
            end
        end

        // Rewriting the same operands must not recompute.
        prev = done_cnt;
        bus.adder_a = vt[9].a;
        bus.adder_b = vt[9].b;
        busy_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (bus.busy) busy_seen = 1'b1;
        end
        check("same_ops_no_done", done_cnt, prev);
        check("same_ops_no_busy", busy_seen, 0);

        // A then B two cycles apart: settle restarts, one result.
        step(1);
        n    = cyc;
        prev = done_cnt;
        bus.adder_a = 64'd3;
        step(2);
        bus.adder_b = 64'd4;
        sb.push_back('{64'd7, 1'b0});
        wait_done(prev, 60, bc, ok);
        check("stagger_done_seen", ok, 1);
        if (ok) check("stagger_latency", done_cyc - n, LAT + 2);
        step(15);
        check("stagger_single_done", done_cnt, prev + 1);

        // Operand change during ADD is deferred to a second pass.
        step(1);
        n    = cyc;
        prev = done_cnt;
        bus.adder_a = 64'd1;
        bus.adder_b = 64'd1;
        sb.push_back('{64'd2, 1'b0});
        step(6);
        check("midadd_busy", bus.busy, 1);
        bus.adder_a = 64'd10;
        sb.push_back('{64'd11, 1'b0});
        wait_done(prev, 60, bc, ok);
        check("midadd_first_done", ok, 1);
        d1 = done_cyc;
        if (ok) check("midadd_first_latency", d1 - n, LAT);
        wait_done(prev + 1, 60, bc, ok);
        check("midadd_second_done", ok, 1);
        if (ok) check("midadd_second_gap", done_cyc - d1, LAT);

        // Reset pulse inside ADD aborts; held operands are recomputed afterwards.
        step(1);
        n    = cyc;
        prev = done_cnt;
        bus.adder_a = 64'd1;
        step(6);
        check("rst_pre_busy", bus.busy, 1);
        rstn = 1'b0;
        step(1);
        rstn = 1'b1;
        check("rst_sum_zero", bus.adder_sum, 0);
        check("rst_busy_low", bus.busy, 0);
        check("rst_done_low", bus.done, 0);
        check("rst_no_done", done_cnt, prev);
        m = cyc;
        sb.push_back('{64'd2, 1'b0});
        wait_done(prev, 60, bc, ok);
        check("rst_recompute_done", ok, 1);
        if (ok) check("rst_recompute_latency", done_cyc - m, LAT);

        step(5);
        check("scoreboard_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
